// File: rtl/alu_hs_seq.sv
// alu_hs_seq: valid/ready ALU with an FSM and an N-cycle restoring divider.
// Define ALU_HS_SEG7_EN to add registered 7-segment outputs of the result.
module alu_hs_seq #(
  parameter int N              = 4,
  parameter bit ZERO_FLAG_FULL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic [3:0]   flags,
  output logic         out_err
`ifdef ALU_HS_SEG7_EN
  ,
  output logic [6:0]   seg_units,
  output logic [6:0]   seg_tens
`endif
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE, S_EXEC, S_DIV, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic [N-1:0] dq_q, dq_d, rm_q, rm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] res_q, res_d, hi_q, hi_d;
  logic [3:0]   flg_q, flg_d;
  logic         err_q, err_d;
  logic         ov_q, ov_d, rdy_q, rdy_d;

  logic [N:0]     sum, dif;
  logic [2*N-1:0] prod;
  logic [N-1:0]   alu_res, alu_hi;
  logic [3:0]     alu_flg;
  logic           alu_c, alu_v, alu_err, alu_ill;
  logic           alu_n, alu_z;

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    dif     = {1'b0, a_q} - {1'b0, b_q};
    prod    = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};
    alu_res = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    alu_ill = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (a_q[N-1] == b_q[N-1]) &&
                  (sum[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        alu_res = dif[N-1:0];
        alu_c   = dif[N];
        alu_v   = (a_q[N-1] != b_q[N-1]) &&
                  (dif[N-1] != a_q[N-1]);
      end
      OP_MUL: {alu_hi, alu_res} = prod;
      // only a zero divisor reaches EXEC with a divide op
      OP_DIV: begin
        alu_res = '1;
        alu_err = 1'b1;
      end
      OP_MOD: begin
        alu_res = a_q;
        alu_err = 1'b1;
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: alu_res = (32'(b_q) >= 32'(N)) ?
                        '0 : (a_q << b_q);
      OP_SHR: alu_res = (32'(b_q) >= 32'(N)) ?
                        '0 : (a_q >> b_q);
      default: begin
        alu_ill = 1'b1;
        alu_err = 1'b1;
      end
    endcase
    alu_n = (op_q == OP_MUL) ? alu_hi[N-1] : alu_res[N-1];
    alu_z = (op_q == OP_MUL && ZERO_FLAG_FULL) ?
            (prod == '0) : (alu_res == '0);
    alu_flg = alu_ill ? 4'b0100 : {alu_n, alu_z, alu_c, alu_v};
  end

  logic [N:0]   trial, tsub;
  logic         qbit;
  logic [N-1:0] qn, rn, dres;

  always_comb begin
    trial = {rm_q, dq_q[N-1]};
    tsub  = trial - {1'b0, b_q};
    qbit  = (trial >= {1'b0, b_q});
    rn    = qbit ? tsub[N-1:0] : trial[N-1:0];
    qn    = {dq_q[N-2:0], qbit};
    dres  = (op_q == OP_DIV) ? qn : rn;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    dq_d    = dq_q;
    rm_d    = rm_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    flg_d   = flg_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && rdy_q) begin
          a_d  = a;
          b_d  = b;
          op_d = op;
          if ((op == OP_DIV || op == OP_MOD) && b != '0) begin
            state_d = S_DIV;
            cnt_d   = '0;
            dq_d    = a;
            rm_d    = '0;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_d   = alu_res;
        hi_d    = alu_hi;
        flg_d   = alu_flg;
        err_d   = alu_err;
        state_d = S_DONE;
      end
      S_DIV: begin
        dq_d  = qn;
        rm_d  = rn;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          res_d   = dres;
          hi_d    = '0;
          flg_d   = {dres[N-1], dres == '0, 2'b00};
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
    ov_d  = (state_d == S_DONE);
    rdy_d = (state_d == S_IDLE);
  end

`ifdef ALU_HS_SEG7_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [31:0] dec_v;
  logic [6:0]  seg_u_q, seg_u_d, seg_t_q, seg_t_d;

  always_comb begin
    dec_v   = 32'(res_d) % 32'd100;
    seg_u_d = 7'h7F;
    seg_t_d = 7'h7F;
    if (state_d == S_DONE) begin
      seg_u_d = seg7(4'(dec_v % 32'd10));
      seg_t_d = seg7(4'(dec_v / 32'd10));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_u_q <= 7'h7F;
      seg_t_q <= 7'h7F;
    end else begin
      seg_u_q <= seg_u_d;
      seg_t_q <= seg_t_d;
    end
  end

  assign seg_units = seg_u_q;
  assign seg_tens  = seg_t_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dq_q    <= '0;
      rm_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      flg_q   <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      dq_q    <= dq_d;
      rm_q    <= rm_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      flg_q   <= flg_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = ov_q;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign flags     = flg_q;
  assign out_err   = err_q;

endmodule
